// File: rtl/fejkon_fc_monitor_if.sv
// fejkon_fc_monitor_if: Avalon-ST bundle (channel, data, framing, empty, valid/ready)
interface fejkon_fc_monitor_if;
  logic [1:0] channel;
  logic [255:0] data;
  logic startofpacket;
  logic endofpacket;
  logic [4:0] empty;
  logic valid;
  logic ready;
  modport master(output channel, data, startofpacket, endofpacket, empty, valid, input ready);
  modport slave(input channel, data, startofpacket, endofpacket, empty, valid, output ready);
endinterface

// File: rtl/fejkon_fc_monitor.sv
// fejkon_fc_monitor: registered Avalon-ST pass-through with per-channel framing counters; option FEJKON_FC_MONITOR_CLEAR_ON_READ_EN
module fejkon_fc_monitor #(
  parameter int CHANNELS = 4,
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic reset,
  fejkon_fc_monitor_if.slave st_in,
  fejkon_fc_monitor_if.master st_out,
  input  logic [7:0] csr_address,
  input  logic csr_write,
  input  logic csr_read,
  input  logic [31:0] csr_writedata,
  output logic [31:0] csr_readdata
);
  logic acc;
  logic clr;
  logic unused_wd;
  logic [5:0] beat_bytes;
  logic [1:0] ch_sel;
  logic [3:0] reg_sel;
  logic [31:0] rd_val;
  logic [CHANNELS-1:0] hit;
  logic [CHANNELS-1:0] cnt_hit;
  logic [CHANNELS-1:0] in_pkt;
  logic [CHANNELS-1:0][3:0] rc;
  logic [CHANNELS-1:0][CNT_W-1:0] pkts, byts, serr, eerr;
  logic [CHANNELS-1:0][CNT_W-1:0] pkts_n, byts_n, serr_n, eerr_n;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [5:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-5){1'b0}}, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  assign st_in.ready = ~st_out.valid | st_out.ready;
  assign acc = st_in.valid & (~st_out.valid | st_out.ready);
  assign hit = acc ? CHANNELS'(1) << st_in.channel : '0;
  // a beat counts bytes when it opens a packet or continues one; orphan continuations only raise sop_err
  assign cnt_hit = hit & (in_pkt | {CHANNELS{st_in.startofpacket}});
  assign beat_bytes = st_in.endofpacket ? 6'd32 - {1'b0, st_in.empty} : 6'd32;
  assign clr = csr_write & (csr_address == 8'hFF) & csr_writedata[0];
  assign unused_wd = ^csr_writedata[31:1];
  assign ch_sel = csr_address[5:4];
  assign reg_sel = csr_address[3:0];

  // per-channel mask of counters zeroed by the current read
  always_comb begin
`ifdef FEJKON_FC_MONITOR_CLEAR_ON_READ_EN
    rc = '0;
    for (int i = 0; i < CHANNELS; i++)
      rc[i] = (csr_read && csr_address[7:6] == 2'b0 && ch_sel == 2'(i) && reg_sel[3:2] == 2'b0) ? 4'b1 << reg_sel[1:0] : 4'b0;
`else
    rc = '0;
`endif
  end

  // next counter values: read-clear base, saturating increment, global clear wins
  always_comb begin
    pkts_n = pkts;
    byts_n = byts;
    serr_n = serr;
    eerr_n = eerr;
    for (int i = 0; i < CHANNELS; i++) begin
      pkts_n[i] = clr ? '0 : sat_add(rc[i][0] ? '0 : pkts[i], {5'b0, cnt_hit[i] & st_in.endofpacket});
      byts_n[i] = clr ? '0 : sat_add(rc[i][1] ? '0 : byts[i], cnt_hit[i] ? beat_bytes : 6'd0);
      serr_n[i] = clr ? '0 : sat_add(rc[i][2] ? '0 : serr[i], {5'b0, hit[i] & ~in_pkt[i] & ~st_in.startofpacket});
      eerr_n[i] = clr ? '0 : sat_add(rc[i][3] ? '0 : eerr[i], {5'b0, hit[i] & in_pkt[i] & st_in.startofpacket});
    end
  end

  // framing state and counters
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      in_pkt <= '0;
      pkts <= '0;
      byts <= '0;
      serr <= '0;
      eerr <= '0;
    end else begin
      in_pkt <= (in_pkt & ~cnt_hit) | (cnt_hit & {CHANNELS{~st_in.endofpacket}});
      pkts <= pkts_n;
      byts <= byts_n;
      serr <= serr_n;
      eerr <= eerr_n;
    end

  // one-deep output register, held while the sink stalls
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st_out.valid <= 1'b0;
      st_out.channel <= '0;
      st_out.data <= '0;
      st_out.startofpacket <= 1'b0;
      st_out.endofpacket <= 1'b0;
      st_out.empty <= '0;
    end else if (acc) begin
      st_out.valid <= 1'b1;
      st_out.channel <= st_in.channel;
      st_out.data <= st_in.data;
      st_out.startofpacket <= st_in.startofpacket;
      st_out.endofpacket <= st_in.endofpacket;
      st_out.empty <= st_in.empty;
    end else if (st_out.ready) begin
      st_out.valid <= 1'b0;
    end

  // CSR read decode
  always_comb
    rd_val = csr_address == 8'hFF ? 32'h0 :
             (csr_address[7:6] != 2'b0 || reg_sel > 4'd4) ? 32'hFFFF_FFFF :
             reg_sel == 4'd0 ? 32'(pkts[ch_sel]) :
             reg_sel == 4'd1 ? 32'(byts[ch_sel]) :
             reg_sel == 4'd2 ? 32'(serr[ch_sel]) :
             reg_sel == 4'd3 ? 32'(eerr[ch_sel]) :
             {31'b0, in_pkt[ch_sel]};

  // registered read data, held between reads
  always_ff @(posedge clk or posedge reset)
    if (reset) csr_readdata <= '0;
    else if (csr_read) csr_readdata <= rd_val;
endmodule

// File: tb/tb_fejkon_fc_monitor.sv
// tb_fejkon_fc_monitor: directed and randomized checks against a queue/array reference model
module tb_fejkon_fc_monitor;
  typedef struct packed {
    logic [1:0] ch;
    logic [255:0] d;
    logic s;
    logic e;
    logic [4:0] em;
  } beat_t;

  localparam longint SAT = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] csr_address;
  logic csr_write, csr_read;
  logic [31:0] csr_writedata, csr_readdata;

  fejkon_fc_monitor_if st_in();
  fejkon_fc_monitor_if st_out();

  fejkon_fc_monitor dut (
    .clk(clk),
    .reset(reset),
    .st_in(st_in),
    .st_out(st_out),
    .csr_address(csr_address),
    .csr_write(csr_write),
    .csr_read(csr_read),
    .csr_writedata(csr_writedata),
    .csr_readdata(csr_readdata)
  );

  always #5 clk = ~clk;

  beat_t pend[$];
  longint m_cnt[4][4];
  bit m_inp[4];
  logic [31:0] m_rd;
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [299:0] got, input logic [299:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void bump(int ch, int r, int inc);
    m_cnt[ch][r] = (m_cnt[ch][r] + inc > SAT) ? SAT : m_cnt[ch][r] + inc;
  endfunction

  function automatic logic [31:0] model_read(logic [7:0] a);
    longint v;
    if (a == 8'hFF) return 32'h0;
    if (a[7:6] != 2'b0 || a[3:0] > 4'd4) return 32'hFFFF_FFFF;
    if (a[3:0] == 4'd4) return {31'b0, m_inp[a[5:4]]};
    v = m_cnt[a[5:4]][a[3:0]];
    return v[31:0];
  endfunction

  task automatic check_outputs();
    chk("out_valid", 300'(st_out.valid), 300'(pend.size() != 0));
    if (pend.size() != 0)
      chk("out_beat", 300'({st_out.channel, st_out.data, st_out.startofpacket, st_out.endofpacket, st_out.empty}), 300'(pend[0]));
    chk("csr_readdata", 300'(csr_readdata), 300'(m_rd));
  endtask

  // drives one cycle at a negedge, predicts the following edge, checks at the next negedge
  task automatic step(input int v, input int s, input int e, input int ch, input int em,
                      input int ordy, input int rd, input int wr, input int a, input int wd);
    beat_t b;
    logic exp_ready;
    b.ch = 2'(ch);
    b.s = 1'(s);
    b.e = 1'(e);
    b.em = 5'(em);
    for (int k = 0; k < 8; k++) b.d[32*k +: 32] = $urandom;
    st_in.valid = 1'(v);
    st_in.channel = b.ch;
    st_in.data = b.d;
    st_in.startofpacket = b.s;
    st_in.endofpacket = b.e;
    st_in.empty = b.em;
    st_out.ready = 1'(ordy);
    csr_read = 1'(rd);
    csr_write = 1'(wr);
    csr_address = 8'(a);
    csr_writedata = 32'(wd);
    #1;
    exp_ready = pend.size() == 0 || ordy != 0;
    chk("in_ready", 300'(st_in.ready), 300'(exp_ready));
    if (pend.size() != 0 && ordy != 0) void'(pend.pop_front());
    if (rd != 0) m_rd = model_read(8'(a));
`ifdef FEJKON_FC_MONITOR_CLEAR_ON_READ_EN
    if (rd != 0 && a < 64 && (a & 15) < 4) m_cnt[(a >> 4) & 3][a & 15] = 0;
`endif
    if (v != 0 && exp_ready) begin
      pend.push_back(b);
      if (b.s && m_inp[b.ch]) bump(b.ch, 3, 1);
      if (!b.s && !m_inp[b.ch]) bump(b.ch, 2, 1);
      else begin
        bump(b.ch, 1, b.e ? 32 - int'(b.em) : 32);
        if (b.e) bump(b.ch, 0, 1);
        m_inp[b.ch] = !b.e;
      end
    end
    if (wr != 0 && a == 255 && (wd & 1) != 0) m_cnt = '{default: 0};
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic rd(input int a);
    step(0, 0, 0, 0, 0, 1, 1, 0, a, 0);
  endtask

  task automatic do_reset();
    st_in.valid = 1'b0;
    csr_read = 1'b0;
    csr_write = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_out_valid", 300'(st_out.valid), 300'(0));
    chk("rst_out_data", 300'(st_out.data), 300'(0));
    chk("rst_in_ready", 300'(st_in.ready), 300'(1));
    chk("rst_readdata", 300'(csr_readdata), 300'(0));
    pend.delete();
    m_cnt = '{default: 0};
    m_inp = '{default: 0};
    m_rd = 32'h0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    st_in.valid = 1'b0;
    st_in.channel = '0;
    st_in.data = '0;
    st_in.startofpacket = 1'b0;
    st_in.endofpacket = 1'b0;
    st_in.empty = '0;
    st_out.ready = 1'b1;
    csr_address = '0;
    csr_write = 1'b0;
    csr_read = 1'b0;
    csr_writedata = '0;
    m_cnt = '{default: 0};
    m_inp = '{default: 0};
    m_rd = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_out_valid", 300'(st_out.valid), 300'(0));
    chk("reset_out_data", 300'(st_out.data), 300'(0));
    chk("reset_in_ready", 300'(st_in.ready), 300'(1));
    chk("reset_readdata", 300'(csr_readdata), 300'(0));
    reset = 1'b0;
    step(1, 1, 0, 1, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 7, 1, 0, 0, 0, 0);
    step(1, 0, 1, 1, 4, 1, 0, 0, 0, 0);
    idle(1);
    rd(8'h10); chk("ch1_packets", 300'(csr_readdata), 300'(1));
    rd(8'h11); chk("ch1_bytes", 300'(csr_readdata), 300'(92));
    rd(8'h12); chk("ch1_sop_err", 300'(csr_readdata), 300'(0));
    rd(8'h13); chk("ch1_eop_err", 300'(csr_readdata), 300'(0));
    step(1, 1, 1, 2, 0, 1, 0, 0, 0, 0);
    rd(8'h21); chk("ch2_bytes", 300'(csr_readdata), 300'(32));
    rd(8'hFF); chk("ctrl_read", 300'(csr_readdata), 300'(0));
    rd(8'h25); chk("bad_reg", 300'(csr_readdata), 300'(32'hFFFF_FFFF));
    step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    rd(8'h02); chk("ch0_sop_err", 300'(csr_readdata), 300'(1));
    rd(8'h03); chk("ch0_eop_err", 300'(csr_readdata), 300'(1));
    rd(8'h00); chk("ch0_packets", 300'(csr_readdata), 300'(1));
    for (int i = 0; i < 6; i++) step(1, i == 0, i == 5, 1, 3, 0, 0, 0, 0, 0);
    idle(3);
    step(1, 1, 1, 2, 1, 1, 0, 1, 8'hFF, 2);
    rd(8'h20);
    step(1, 1, 0, 3, 0, 1, 0, 0, 0, 0);
    step(1, 0, 1, 3, 0, 1, 0, 1, 8'hFF, 1);
    rd(8'h30); chk("clr_ch3_packets", 300'(csr_readdata), 300'(0));
    rd(8'h31); chk("clr_ch3_bytes", 300'(csr_readdata), 300'(0));
    rd(8'h11); chk("clr_ch1_bytes", 300'(csr_readdata), 300'(0));
    step(1, 1, 0, 3, 0, 1, 0, 0, 0, 0);
    do_reset();
    rd(8'h34); chk("rst_ch3_state", 300'(csr_readdata), 300'(0));
    step(1, 0, 0, 3, 0, 1, 0, 0, 0, 0);
    rd(8'h32); chk("rst_ch3_sop_err", 300'(csr_readdata), 300'(1));
    step(0, 0, 0, 0, 0, 1, 0, 1, 8'hFF, 1);
    step(1, 1, 1, 0, 0, 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 1, 0, 0, 0, 0);
    idle(1);
    rd(8'h00); chk("cor_first", 300'(csr_readdata), 300'(2));
    rd(8'h00);
`ifdef FEJKON_FC_MONITOR_CLEAR_ON_READ_EN
    chk("cor_second", 300'(csr_readdata), 300'(0));
`else
    chk("cor_second", 300'(csr_readdata), 300'(2));
`endif
    repeat (800) begin
      int a, r;
      r = $urandom_range(0, 9);
      a = int'(($urandom_range(0, 3) << 4) | $urandom_range(0, 5));
      if (r == 7) a = 255;
      if (r > 7) a = int'($urandom_range(0, 255));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) < 2, $urandom_range(0, 4) < 2,
           int'($urandom_range(0, 3)), int'($urandom_range(0, 31)), $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 3, $urandom_range(0, 29) == 0, a, int'($urandom_range(0, 1)));
    end
    idle(3);
    for (int c = 0; c < 4; c++)
      for (int g = 0; g < 5; g++) rd(c * 16 + g);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
